mips_mem_sequencer: RTL and testbench



---
 rtl/mips_mem_sequencer.sv | 143 ++++++++++++++
 tb/tb_mips_mem_sequencer.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_mem_sequencer.sv
// Serialises a Harvard MIPS core's instruction fetch and optional data access onto one
// shared wait-stated memory port, releasing the core for exactly one enabled cycle per step.
module mips_mem_sequencer #(
    parameter int unsigned MAX_WAIT = 16,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cpu_active,
    output logic             cpu_clk_enable,
    input  logic [31:0]      cpu_instr_address,
    output logic [31:0]      cpu_instr_readdata,
    input  logic [31:0]      cpu_data_address,
    input  logic             cpu_data_read,
    input  logic             cpu_data_write,
    input  logic [31:0]      cpu_data_writedata,
    output logic [31:0]      cpu_data_readdata,
    output logic [31:0]      mem_address,
    output logic             mem_read,
    output logic             mem_write,
    output logic [31:0]      mem_writedata,
    input  logic [31:0]      mem_readdata,
    input  logic             mem_waitrequest,
    output logic [CNT_W-1:0] step_count,
    output logic             halted,
    output logic             error
);

    typedef enum logic [1:0] {FETCH, DATA, STEP, HALT} state_t;

    localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 2);

    state_t            state;
    state_t            state_next;
    logic [WAIT_W-1:0] wait_cnt;
    logic              access;
    logic              load;
    logic              done;
    logic              timeout;

    // A store wins over a simultaneous load; that combination only flags error.
    always_comb begin
        load    = cpu_data_read && !cpu_data_write;
        access  = (state == FETCH) ||
                  ((state == DATA) && (cpu_data_read || cpu_data_write));
        done    = access && !mem_waitrequest;
        timeout = access && mem_waitrequest && (wait_cnt == WAIT_W'(MAX_WAIT));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= FETCH;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            FETCH: begin
                if (timeout) begin
                    state_next = HALT;
                end else if (done) begin
                    state_next = DATA;
                end
            end
            DATA: begin
                if (!access) begin
                    state_next = STEP;
                end else if (timeout) begin
                    state_next = HALT;
                end else if (done) begin
                    state_next = STEP;
                end
            end
            STEP:    state_next = cpu_active ? FETCH : HALT;
            default: state_next = HALT;
        endcase
    end

    // Strobes are gated by reset so they fall asynchronously, not at the next edge.
    always_comb begin
        cpu_clk_enable = (state == STEP);
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        mem_address    = '0;
        mem_writedata  = '0;
        if (reset) begin
            case (state)
                FETCH: begin
                    mem_read    = 1'b1;
                    mem_address = cpu_instr_address;
                end
                DATA: begin
                    if (cpu_data_write) begin
                        mem_write     = 1'b1;
                        mem_address   = cpu_data_address;
                        mem_writedata = cpu_data_writedata;
                    end else if (cpu_data_read) begin
                        mem_read    = 1'b1;
                        mem_address = cpu_data_address;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt           <= '0;
            cpu_instr_readdata <= '0;
            cpu_data_readdata  <= '0;
            step_count         <= '0;
            halted             <= 1'b0;
            error              <= 1'b0;
        end else begin
            if (access && mem_waitrequest && !timeout) begin
                wait_cnt <= wait_cnt + WAIT_W'(1);
            end else begin
                wait_cnt <= '0;
            end
            if ((state == FETCH) && done) begin
                cpu_instr_readdata <= mem_readdata;
            end
            if ((state == DATA) && load && done) begin
                cpu_data_readdata <= mem_readdata;
            end
            if (state == STEP) begin
                if (cpu_active) begin
                    step_count <= step_count + CNT_W'(1);
                end else begin
                    halted <= 1'b1;
                end
            end
            if (timeout || ((state == DATA) && cpu_data_read && cpu_data_write)) begin
                error <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mips_mem_sequencer.sv
// Randomised step-level bench: a wait-stated memory responder plus a transaction model
// predicting step latency, fetched/loaded words, write beats, counters and sticky flags.
module tb_mips_mem_sequencer;

    localparam int unsigned MAX_WAIT = 16;
    localparam int unsigned CNT_W    = 32;
    localparam int OP_NONE = 0;
    localparam int OP_LD   = 1;
    localparam int OP_ST   = 2;
    localparam int OP_BOTH = 3;

    logic             clk;
    logic             reset;
    logic             cpu_active;
    logic             cpu_clk_enable;
    logic [31:0]      cpu_instr_address;
    logic [31:0]      cpu_instr_readdata;
    logic [31:0]      cpu_data_address;
    logic             cpu_data_read;
    logic             cpu_data_write;
    logic [31:0]      cpu_data_writedata;
    logic [31:0]      cpu_data_readdata;
    logic [31:0]      mem_address;
    logic             mem_read;
    logic             mem_write;
    logic [31:0]      mem_writedata;
    logic [31:0]      mem_readdata;
    logic             mem_waitrequest;
    logic [CNT_W-1:0] step_count;
    logic             halted;
    logic             error;

    mips_mem_sequencer #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
        .clk                (clk),
        .reset              (reset),
        .cpu_active         (cpu_active),
        .cpu_clk_enable     (cpu_clk_enable),
        .cpu_instr_address  (cpu_instr_address),
        .cpu_instr_readdata (cpu_instr_readdata),
        .cpu_data_address   (cpu_data_address),
        .cpu_data_read      (cpu_data_read),
        .cpu_data_write     (cpu_data_write),
        .cpu_data_writedata (cpu_data_writedata),
        .cpu_data_readdata  (cpu_data_readdata),
        .mem_address        (mem_address),
        .mem_read           (mem_read),
        .mem_write          (mem_write),
        .mem_writedata      (mem_writedata),
        .mem_readdata       (mem_readdata),
        .mem_waitrequest    (mem_waitrequest),
        .step_count         (step_count),
        .halted             (halted),
        .error              (error)
    );

    int               n_checks = 0;
    int               n_fail   = 0;
    logic [31:0]      mem [logic [31:0]];
    int               plan [$];
    logic [63:0]      wlog [$];
    logic [CNT_W-1:0] exp_sc;
    logic [31:0]      exp_dr;
    logic             exp_err;
    logic             exp_halt;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Memory responder: each new access takes its wait count from the plan queue.
    initial begin : responder
        bit          busy;
        int          remaining;
        bit          stable;
        logic [65:0] cap;
        busy = 0;
        remaining = 0;
        stable = 1;
        cap = '0;
        mem_waitrequest = 1'b0;
        mem_readdata = '0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                busy = 0;
            end else if (mem_read || mem_write) begin
                if (!busy) begin
                    busy = 1;
                    stable = 1;
                    remaining = (plan.size() > 0) ? plan.pop_front() : 0;
                    cap = {mem_read, mem_write, mem_address, mem_writedata};
                end else if (cap != {mem_read, mem_write, mem_address, mem_writedata}) begin
                    stable = 0;
                end
                if (remaining > 0) begin
                    remaining--;
                    mem_waitrequest = 1'b1;
                    mem_readdata = $urandom;
                end else begin
                    mem_waitrequest = 1'b0;
                    mem_readdata = mem.exists(mem_address) ? mem[mem_address] : 32'h0;
                    if (mem_write) begin
                        wlog.push_back({mem_address, mem_writedata});
                        mem[mem_address] = mem_writedata;
                    end
                    check("strobe_stable", 64'(stable), 64'(1));
                    busy = 0;
                end
            end else begin
                busy = 0;
                mem_waitrequest = 1'($urandom_range(0, 1));
                mem_readdata = $urandom;
            end
        end
    end

    task automatic check_reset_values(input string tag);
        check({tag, "_clk_en"},  64'(cpu_clk_enable), 64'(0));
        check({tag, "_rd"},      64'(mem_read), 64'(0));
        check({tag, "_wr"},      64'(mem_write), 64'(0));
        check({tag, "_addr"},    64'(mem_address), 64'(0));
        check({tag, "_wdata"},   64'(mem_writedata), 64'(0));
        check({tag, "_ireg"},    64'(cpu_instr_readdata), 64'(0));
        check({tag, "_dreg"},    64'(cpu_data_readdata), 64'(0));
        check({tag, "_count"},   64'(step_count), 64'(0));
        check({tag, "_halted"},  64'(halted), 64'(0));
        check({tag, "_error"},   64'(error), 64'(0));
    endtask

    task automatic release_reset();
        @(negedge clk);
        plan.delete();
        wlog.delete();
        @(posedge clk);
        #2 reset = 1'b1;
        exp_sc   = '0;
        exp_dr   = '0;
        exp_err  = 1'b0;
        exp_halt = 1'b0;
    endtask

    // One CPU step: predicted latency is (fetch waits + 1) + (data waits + 1 or 1) + 1.
    task automatic run_step(input logic [31:0] ia, input logic [31:0] inst, input int op,
                            input logic [31:0] da, input logic [31:0] wd, input logic [31:0] ldv,
                            input int fw, input int dw, input logic act);
        bit rd;
        bit wr;
        int n;
        int c;
        wr = (op == OP_ST) || (op == OP_BOTH);
        rd = (op == OP_LD) || (op == OP_BOTH);
        mem[ia] = inst;
        if (rd) mem[da] = ldv;
        cpu_instr_address  = ia;
        cpu_data_address   = da;
        cpu_data_read      = rd;
        cpu_data_write     = wr;
        cpu_data_writedata = wd;
        cpu_active         = act;
        plan.push_back(fw);
        if (rd || wr) plan.push_back(dw);
        n = (fw + 1) + ((rd || wr) ? dw + 1 : 1) + 1;
        wlog.delete();
        c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (!cpu_clk_enable && c < n + 8);
        check("step_cycle", 64'(c), 64'(n));
        check("instr_reg", 64'(cpu_instr_readdata), 64'(inst));
        if (rd && !wr) exp_dr = ldv;
        if (rd && wr) exp_err = 1'b1;
        check("data_reg", 64'(cpu_data_readdata), 64'(exp_dr));
        check("count_at_step", 64'(step_count), 64'(exp_sc));
        check("write_beats", 64'(wlog.size()), wr ? 64'(1) : 64'(0));
        if (wr && wlog.size() == 1) check("write_beat", wlog[0], {da, wd});
        check("error_flag", 64'(error), 64'(exp_err));
        @(posedge clk);
        #1;
        if (act) exp_sc = exp_sc + CNT_W'(1);
        else exp_halt = 1'b1;
        check("count_after", 64'(step_count), 64'(exp_sc));
        check("halted_flag", 64'(halted), 64'(exp_halt));
        check("enable_single", 64'(cpu_clk_enable), 64'(0));
    endtask

    initial begin : main
        logic [31:0] da;
        int          r;
        int          op;
        reset = 1'b0;
        cpu_active = 1'b1;
        cpu_instr_address = '0;
        cpu_data_address = '0;
        cpu_data_read = 1'b0;
        cpu_data_write = 1'b0;
        cpu_data_writedata = '0;
        exp_sc = '0;
        exp_dr = '0;
        exp_err = 1'b0;
        exp_halt = 1'b0;
        #1;
        check_reset_values("por");
        release_reset();

        run_step(32'h0, 32'h24030F0F, OP_NONE, 32'h0, 32'h0, 32'h0, 0, 0, 1'b1);
        run_step(32'h4, $urandom, OP_LD, 32'h1000, 32'h0, 32'h00000FFF, 2, 2, 1'b1);
        run_step(32'h8, $urandom, OP_ST, 32'h1004, 32'hDEADBEEF, 32'h0, 3, 3, 1'b1);
        run_step(32'hC, $urandom, OP_LD, 32'h1008, 32'h0, $urandom, MAX_WAIT, MAX_WAIT, 1'b1);

        for (int i = 0; i < 60; i++) begin
            r  = $urandom_range(0, 15);
            op = (r == 0) ? OP_BOTH : (r <= 5) ? OP_NONE : (r <= 10) ? OP_LD : OP_ST;
            da = 32'h1000 + 32'($urandom_range(0, 1023)) * 4;
            run_step(32'($urandom_range(0, 1023)) * 4, $urandom, op, da, $urandom, $urandom,
                     $urandom_range(0, 4), $urandom_range(0, 4), 1'b1);
        end
        run_step(32'h40, $urandom, OP_BOTH, 32'h1010, 32'h13572468, 32'h0BADF00D, 1, 2, 1'b1);

        // Reset asserted while a load is waiting in DATA.
        da = 32'h1020;
        mem[32'h80] = $urandom;
        mem[da] = $urandom;
        cpu_instr_address = 32'h80;
        cpu_data_address = da;
        cpu_data_read = 1'b1;
        cpu_data_write = 1'b0;
        cpu_active = 1'b1;
        plan.push_back(0);
        plan.push_back(5);
        @(negedge clk);
        @(negedge clk);
        check("mid_data_read", 64'(mem_read), 64'(1));
        check("mid_data_addr", 64'(mem_address), 64'(da));
        #2 reset = 1'b0;
        #1;
        check_reset_values("mid");
        release_reset();
        run_step(32'h84, $urandom, OP_NONE, 32'h0, 32'h0, 32'h0, 0, 0, 1'b1);

        // Bus stuck busy on a fetch.
        reset = 1'b0;
        release_reset();
        cpu_instr_address = 32'h100;
        cpu_data_read = 1'b0;
        cpu_data_write = 1'b0;
        plan.push_back(1000);
        for (int c = 1; c <= int'(MAX_WAIT) + 1; c++) @(negedge clk);
        check("timeout_strobe_held", 64'(mem_read), 64'(1));
        check("timeout_not_early", 64'(error), 64'(0));
        @(negedge clk);
        check("timeout_error", 64'(error), 64'(1));
        check("timeout_strobes", 64'({mem_read, mem_write}), 64'(0));
        check("timeout_count", 64'(step_count), 64'(0));
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("timeout_quiet", 64'({mem_read, mem_write, cpu_clk_enable}), 64'(0));
        end

        // CPU reports halt at STEP.
        reset = 1'b0;
        release_reset();
        run_step(32'h200, $urandom, OP_LD, 32'h1100, 32'h0, $urandom, 1, 0, 1'b1);
        run_step(32'h204, $urandom, OP_NONE, 32'h0, 32'h0, 32'h0, 0, 0, 1'b0);
        cpu_active = 1'b1;
        cpu_data_write = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check("halt_quiet", 64'({mem_read, mem_write, cpu_clk_enable}), 64'(0));
        end
        check("halt_sticky", 64'(halted), 64'(1));
        check("halt_count", 64'(step_count), 64'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
